// File: rtl/bus_mux_reg_if.sv
// rtl/bus_mux_reg_if.sv - source/bus signal bundle for the registered bus multiplexer
interface bus_mux_reg_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 32,
    parameter int SEL_W   = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0]       src_en;
    logic [NUM_SRC*WIDTH-1:0] data_in;
    logic                     hold;
    logic                     clr_conflict;
    logic [WIDTH-1:0]         bus_out;
    logic                     bus_valid;
    logic [SEL_W-1:0]         sel_code;
    logic                     conflict;
    logic [7:0]               conflict_cnt;

    modport master (
        output src_en, data_in, hold, clr_conflict,
        input  bus_out, bus_valid, sel_code, conflict, conflict_cnt
    );

    modport slave (
        input  src_en, data_in, hold, clr_conflict,
        output bus_out, bus_valid, sel_code, conflict, conflict_cnt
    );
endinterface

// File: rtl/bus_mux_reg.sv
// rtl/bus_mux_reg.sv - registered priority bus mux with hold and sticky multi-driver conflict counting
module bus_mux_reg #(
    parameter int WIDTH     = 32,
    parameter int NUM_SRC   = 32,
    parameter int SEL_W     = $clog2(NUM_SRC),
    parameter bit ZERO_IDLE = 1'b1
) (
    input logic          clk,
    input logic          clr,
    bus_mux_reg_if.slave bus
);
    logic               win_found;
    logic [SEL_W-1:0]   win_idx;
    logic [WIDTH-1:0]   win_data;
    logic [NUM_SRC-1:0] en_less;
    logic               multi;

    logic [WIDTH-1:0]   bus_q;
    logic               valid_q;
    logic [SEL_W-1:0]   sel_q;
    logic               conflict_q;
    logic [7:0]         cnt_q;

    // Descending scan so the lowest enabled index is the last (winning) assignment.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (bus.src_en[i]) begin
                win_found = 1'b1;
                win_idx   = SEL_W'(i);
                win_data  = bus.data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more enables are set.
    assign en_less = bus.src_en - {{(NUM_SRC-1){1'b0}}, 1'b1};
    assign multi   = |(bus.src_en & en_less);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bus_q      <= '0;
            valid_q    <= 1'b0;
            sel_q      <= '0;
            conflict_q <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            if (!bus.hold) begin
                valid_q <= win_found;
                sel_q   <= win_idx;
                if (win_found) begin
                    bus_q <= win_data;
                end else if (ZERO_IDLE) begin
                    bus_q <= '0;
                end
            end
            if (bus.clr_conflict) begin
                conflict_q <= 1'b0;
                cnt_q      <= 8'd0;
            end else if (!bus.hold && multi) begin
                conflict_q <= 1'b1;
                if (cnt_q != 8'hFF) begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    assign bus.bus_out      = bus_q;
    assign bus.bus_valid    = valid_q;
    assign bus.sel_code     = sel_q;
    assign bus.conflict     = conflict_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_bus_mux_reg.sv
// tb/tb_bus_mux_reg.sv - randomized and directed checks of bus_mux_reg against a behavioural model
module tb_bus_mux_reg;
    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    bus_mux_reg_if #(.WIDTH(32), .NUM_SRC(32)) ifa ();
    bus_mux_reg_if #(.WIDTH(32), .NUM_SRC(32)) ifb ();
    bus_mux_reg_if #(.WIDTH(16), .NUM_SRC(5))  ifc ();

    bus_mux_reg #(.WIDTH(32), .NUM_SRC(32), .ZERO_IDLE(1'b1)) dut_a (.clk(clk), .clr(clr), .bus(ifa.slave));
    bus_mux_reg #(.WIDTH(32), .NUM_SRC(32), .ZERO_IDLE(1'b0)) dut_b (.clk(clk), .clr(clr), .bus(ifb.slave));
    bus_mux_reg #(.WIDTH(16), .NUM_SRC(5),  .ZERO_IDLE(1'b1)) dut_c (.clk(clk), .clr(clr), .bus(ifc.slave));

    int tests  = 0;
    int failed = 0;

    logic [31:0] en_v;
    logic        hold_v;
    logic        cc_v;
    logic [31:0] dat [32];

    logic [31:0] m_bus1, m_bus0;
    logic        m_valid;
    logic [4:0]  m_sel;
    logic        m_conf;
    int          m_cnt;

    logic [4:0]  en_s;
    logic [15:0] dat_s [5];
    logic [15:0] ms_bus;
    logic [2:0]  ms_sel;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_index(input logic [31:0] v);
        logic [31:0] iso;
        int idx;
        iso = v & (~v + 32'd1);
        idx = 0;
        while ((iso >> idx) != 32'd1) idx++;
        return idx;
    endfunction

    task automatic apply();
        ifa.src_en = en_v;  ifb.src_en = en_v;
        ifa.hold = hold_v;  ifb.hold = hold_v;
        ifa.clr_conflict = cc_v; ifb.clr_conflict = cc_v;
        for (int i = 0; i < 32; i++) begin
            ifa.data_in[i*32 +: 32] = dat[i];
            ifb.data_in[i*32 +: 32] = dat[i];
        end
    endtask

    task automatic model_reset();
        m_bus1 = 0; m_bus0 = 0; m_valid = 0; m_sel = 0; m_conf = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        int w;
        if (!hold_v) begin
            if (en_v != 0) begin
                w = lowest_index(en_v);
                m_bus1 = dat[w]; m_bus0 = dat[w]; m_sel = 5'(w); m_valid = 1;
            end else begin
                m_bus1 = 0; m_valid = 0; m_sel = 0;
            end
        end
        if (cc_v) begin
            m_conf = 0; m_cnt = 0;
        end else if (!hold_v && $countones(en_v) >= 2) begin
            m_conf = 1;
            m_cnt  = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".bus_z"},   64'(ifa.bus_out),      64'(m_bus1));
        check({tag, ".bus_h"},   64'(ifb.bus_out),      64'(m_bus0));
        check({tag, ".valid"},   64'(ifa.bus_valid),    64'(m_valid));
        check({tag, ".valid_h"}, 64'(ifb.bus_valid),    64'(m_valid));
        check({tag, ".sel"},     64'(ifa.sel_code),     64'(m_sel));
        check({tag, ".conf"},    64'(ifa.conflict),     64'(m_conf));
        check({tag, ".cnt"},     64'(ifa.conflict_cnt), 64'(m_cnt));
        check({tag, ".cnt_h"},   64'(ifb.conflict_cnt), 64'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_s();
        ifc.src_en = en_s;
        for (int i = 0; i < 5; i++) ifc.data_in[i*16 +: 16] = dat_s[i];
    endtask

    initial begin
        en_v = 0; hold_v = 0; cc_v = 0;
        for (int i = 0; i < 32; i++) dat[i] = $urandom;
        apply();
        en_s = 0;
        for (int i = 0; i < 5; i++) dat_s[i] = 16'($urandom);
        apply_s();
        ifc.hold = 0; ifc.clr_conflict = 0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset.small_sel", 64'(ifc.sel_code), 64'd0);
        @(negedge clk);
        clr = 1'b1;

        // Walking one-hot sources
        for (int i = 0; i < 32; i++) begin
            dat[i] = 32'hA500_0000 + 32'(i);
            en_v = 32'd1 << i;
            apply();
            tick();
            check_all("walk");
            check("walk.bus_const", 64'(ifa.bus_out), 64'(32'hA500_0000 + 32'(i)));
            check("walk.sel_const", 64'(ifa.sel_code), 64'(i));
        end

        en_v = 32'h8000_0006; apply(); tick();
        check_all("prio");
        check("prio.sel_const", 64'(ifa.sel_code), 64'd1);
        check("prio.cnt_const", 64'(ifa.conflict_cnt), 64'd1);

        for (int i = 0; i < 300; i++) begin
            en_v = 32'h3 << $urandom_range(0, 30);
            apply(); tick();
        end
        check_all("sat");
        check("sat.cnt_const", 64'(ifa.conflict_cnt), 64'd255);

        cc_v = 1; en_v = 32'h0000_0101; apply(); tick();
        check_all("clrconf");
        check("clrconf.cnt_const", 64'(ifa.conflict_cnt), 64'd0);
        cc_v = 0;

        dat[3] = 32'hDEAD_BEEF; en_v = 32'h8; apply(); tick();
        check_all("idle_load");
        en_v = 0; apply(); tick();
        check_all("idle");
        check("idle.zero_const", 64'(ifa.bus_out), 64'd0);
        check("idle.keep_const", 64'(ifb.bus_out), 64'hDEAD_BEEF);

        en_v = 32'h80; apply(); tick();
        check_all("hold_load");
        hold_v = 1; en_v = 32'h0000_0300;
        for (int i = 0; i < 3; i++) begin
            apply(); tick();
            check_all("hold");
            check("hold.sel_const", 64'(ifa.sel_code), 64'd7);
        end
        hold_v = 0; apply(); tick();
        check_all("hold_rel");
        check("hold_rel.sel_const", 64'(ifa.sel_code), 64'd8);

        // Randomized traffic with holds and clears mixed in
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0: en_v = 0;
                1: en_v = 32'd1 << $urandom_range(0, 31);
                2: en_v = $urandom;
                default: en_v = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
            endcase
            hold_v = ($urandom_range(0, 3) == 0);
            cc_v   = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 32; i++) dat[i] = $urandom;
            apply(); tick();
            check_all("rand");
        end
        hold_v = 0; cc_v = 0;

        // Asynchronous clear in the middle of a cycle
        en_v = 32'h0000_0010; apply(); tick();
        check_all("pre_rst");
        clr = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        #2;
        clr = 1'b1;
        tick();
        check_all("post_rst");
        check("post_rst.sel_const", 64'(ifa.sel_code), 64'd4);

        // Narrow, non-power-of-two instance
        en_s = 5'b10000; apply_s();
        @(posedge clk); #1;
        check("small.sel", 64'(ifc.sel_code), 64'd4);
        check("small.bus", 64'(ifc.bus_out), 64'(dat_s[4]));
        for (int n = 0; n < 20; n++) begin
            en_s = 5'($urandom_range(1, 31));
            for (int i = 0; i < 5; i++) dat_s[i] = 16'($urandom);
            apply_s();
            ms_sel = 3'(lowest_index(32'(en_s)));
            ms_bus = dat_s[ms_sel];
            @(posedge clk); #1;
            check("small.rsel", 64'(ifc.sel_code), 64'(ms_sel));
            check("small.rbus", 64'(ifc.bus_out), 64'(ms_bus));
            check("small.rconf", 64'(ifc.conflict), 64'(ifc.conflict | ($countones(en_s) >= 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/bus_mux_reg.md
# bus_mux_reg

Registered, parametrised N-source datapath bus multiplexer that replaces the purely combinational 32-to-1 bus mux. Sources are selected by per-source one-hot output enables, as the register file and functional units drive them. The winner is priority-encoded, its data is registered onto the bus, and the encoded index is exported. The block also provides a stall/hold input and sticky detection and counting of multi-driver conflicts for debug.

## Interface
- WIDTH, 32, data width of each source and of the bus
- NUM_SRC, 32, number of sources (2..64)
- SEL_W, $clog2(NUM_SRC), width of the encoded select output
- ZERO_IDLE, 1, 1: bus is driven to zero when no source is enabled; 0: bus keeps its previous value
- clk  input  1  single clock; all state updates on its rising edge
- clr  input  1  reset, asynchronous, active-low; clears all state immediately when low
- src_en  input  NUM_SRC  per-source output enables; bit i requests source i
- data_in  input  NUM_SRC*WIDTH  packed source data; source i at [i*WIDTH +: WIDTH]
- hold  input  1  stall; while high, all output registers and the conflict count are frozen
- clr_conflict  input  1  synchronous clear of conflict and conflict_cnt
- bus_out  output  WIDTH  registered bus value
- bus_valid  output  1  high when bus_out was loaded from an enabled source on the last load
- sel_code  output  SEL_W  index of the source loaded on the last load
- conflict  output  1  sticky flag: two or more enables seen in one non-held cycle
- conflict_cnt  output  8  saturating count of conflict cycles

## Operation
- Reset (clr=0, asynchronous): bus_out=0, bus_valid=0, sel_code=0, conflict=0, conflict_cnt=0.
- Load cycle (hold=0): the winner is the lowest index i with src_en[i]=1.
  - If a winner exists: bus_out<=data_in[winner], sel_code<=winner, bus_valid<=1.
  - If no enable is set: bus_valid<=0 and sel_code<=0. bus_out<=0 when ZERO_IDLE=1; bus_out holds when ZERO_IDLE=0.
- Conflict: popcount(src_en)>=2 in a load cycle sets conflict<=1 and increments conflict_cnt. The count saturates at 255 and never wraps. The lowest-index winner is still loaded.
- Hold (hold=1): bus_out, bus_valid, sel_code and conflict_cnt keep their values. src_en is ignored, so no conflict is detected while held.
- clr_conflict=1: conflict<=0 and conflict_cnt<=0 on the next edge, regardless of hold. It takes priority over a simultaneous conflict, so the result is 0 and 0.
- Source indices at or above NUM_SRC do not exist. SEL_W is wide enough for NUM_SRC-1.

## Timing
- Latency is 1 cycle: src_en and data_in sampled at edge k appear on bus_out, sel_code and bus_valid after edge k.
- Throughput: one new selection per cycle when hold=0.
- Combinational paths:
  - The priority encoder and the NUM_SRC:1 data select are the only combinational logic before the output registers.
  - There is no combinational path from any input to any output.
- conflict and conflict_cnt update on the same edge as the bus load that observed the conflict.
- Reset mid-operation: the asynchronous clear wins over any load or hold. The first load after clr rises occurs on the first rising edge with clr=1.
- hold asserted and released: the first edge with hold=0 loads the then-current inputs. Nothing captured before the hold is replayed.

## Test plan
- Reset: drive clr=0 mid-stream with src_en=32'h0000_0010 → all outputs read 0 immediately, before any clock edge. After release, the next edge gives sel_code=4 and bus_out=data_in[4].
- Walk: one-hot src_en=1<<i for i=0..31, with data_in[i]=32'hA500_0000+i → one cycle later bus_out=32'hA500_0000+i, sel_code=i, bus_valid=1, conflict=0.
- Conflict and priority: src_en=32'h8000_0006 → bus_out=data_in[1], sel_code=1, conflict=1, conflict_cnt=1. After 300 conflict cycles, conflict_cnt=255. clr_conflict=1 on a conflict cycle → conflict=0, conflict_cnt=0.
- Idle:
  - ZERO_IDLE=1, src_en=0 after loading 32'hDEAD_BEEF → bus_out=0, bus_valid=0.
  - ZERO_IDLE=0, same stimulus → bus_out stays 32'hDEAD_BEEF, bus_valid=0.
- Hold: load source 7, then assert hold for 3 cycles with src_en=32'h0000_0300 → outputs stay at source 7 and conflict_cnt is unchanged. On release, the next edge gives sel_code=8 and conflict=1.
- Parametrisation: WIDTH=16, NUM_SRC=5 (SEL_W=3) → src_en=5'b10000 gives sel_code=4 and the correct 16-bit bus_out.
